// File: rtl/ctrl_fsm_pkg.sv
// Shared types for the multi-cycle control sequencer: opcodes, ALU mnemonics, FSM states, decode bundle.
package ctrl_fsm_pkg;

    localparam int IW  = 9;
    localparam int OPW = 4;
    localparam int RAW = 3;

    typedef enum logic [OPW-1:0] {
        I_ADD  = 4'd0,  I_SUB  = 4'd1,  I_AND  = 4'd2,  I_OR   = 4'd3,
        I_XOR  = 4'd4,  I_SHL  = 4'd5,  I_SHR  = 4'd6,  I_MOV  = 4'd7,
        I_BEQ  = 4'd8,  I_BNE  = 4'd9,  I_LDR  = 4'd10, I_STR  = 4'd11,
        I_RSV0 = 4'd12, I_RSV1 = 4'd13, I_RSV2 = 4'd14, I_HALT = 4'd15
    } instr_op_e;

    typedef enum logic [OPW-1:0] {
        kNOP = 4'd0, kADD = 4'd1, kSUB = 4'd2,  kAND = 4'd3,
        kOR  = 4'd4, kXOR = 4'd5, kSHL = 4'd6,  kSHR = 4'd7,
        kMOV = 4'd8, kBEQ = 4'd9, kBNE = 4'd10, kADR = 4'd11
    } op_mne_e;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP
    } ctrl_state_e;

    typedef struct packed {
        op_mne_e alu_op;
        logic    is_branch;
        logic    is_mem;
        logic    is_store;
        logic    wr_en;
        logic    is_halt;
        logic    illegal;
    } ctrl_t;

    function automatic logic [RAW-1:0] rs_of(input logic [IW-1:0] ir);
        return ir[4:2];
    endfunction

    function automatic logic [RAW-1:0] rt_of(input logic [IW-1:0] ir);
        return {1'b0, ir[1:0]};
    endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Sequencer-facing bus: ROM word, ALU flag and memory handshake in; ALU/regfile/memory/PC controls out.
interface ctrl_fsm_if
    import ctrl_fsm_pkg::*;
();
    logic           start;
    logic [IW-1:0]  instruction;
    logic           jump;
    logic           mem_ack;
    op_mne_e        alu_op;
    logic [RAW-1:0] rd_addr_a;
    logic [RAW-1:0] rd_addr_b;
    logic           reg_wr_en;
    logic           mem_req;
    logic           mem_wr_en;
    logic           pc_en;
    logic           branch_taken;
    logic           done;
    logic           illegal_op;

    modport master (
        input  start, instruction, jump, mem_ack,
        output alu_op, rd_addr_a, rd_addr_b, reg_wr_en, mem_req, mem_wr_en,
               pc_en, branch_taken, done, illegal_op
    );

    modport slave (
        output start, instruction, jump, mem_ack,
        input  alu_op, rd_addr_a, rd_addr_b, reg_wr_en, mem_req, mem_wr_en,
               pc_en, branch_taken, done, illegal_op
    );
endinterface

// File: rtl/ctrl_fsm_instr_decode.sv
// Combinational opcode decoder: IR[8:5] -> control bundle for the sequencer.
module instr_decode
    import ctrl_fsm_pkg::*;
(
    input  logic [OPW-1:0] opcode_i,
    output ctrl_t          ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (instr_op_e'(opcode_i))
            // ALU mnemonics are laid out one above the matching opcode
            I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SHL, I_SHR, I_MOV: begin
                ctrl_o.alu_op = op_mne_e'(opcode_i + 4'd1);
                ctrl_o.wr_en  = 1'b1;
            end
            I_BEQ: begin
                ctrl_o.alu_op    = kBEQ;
                ctrl_o.is_branch = 1'b1;
            end
            I_BNE: begin
                ctrl_o.alu_op    = kBNE;
                ctrl_o.is_branch = 1'b1;
            end
            I_LDR: begin
                ctrl_o.alu_op = kADR;
                ctrl_o.is_mem = 1'b1;
                ctrl_o.wr_en  = 1'b1;
            end
            I_STR: begin
                ctrl_o.alu_op   = kADR;
                ctrl_o.is_mem   = 1'b1;
                ctrl_o.is_store = 1'b1;
            end
            I_HALT:  ctrl_o.is_halt = 1'b1;
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control sequencer FETCH/DECODE/EXEC/[MEM]/WB with HALT.
// Optional ILLEGAL_TRAP_EN: reserved opcodes trap (sticky IllegalOp) instead of retiring as NOP.
module ctrl_fsm
    import ctrl_fsm_pkg::*;
(
    input logic        clk_i,
    input logic        rst_i,
    ctrl_fsm_if.master bus
);

    ctrl_state_e   state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    op_mne_e       alu_op_q, alu_op_d;
    ctrl_t         dec;
    logic          reg_wr, mem_req, mem_wr, pc_en, br_taken, done;

    instr_decode u_decode (
        .opcode_i (ir_q[IW-1 -: OPW]),
        .ctrl_o   (dec)
    );

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`else
    logic unused_illegal;
    assign unused_illegal = dec.illegal;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ir_q     <= '0;
            alu_op_q <= kNOP;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            alu_op_q <= alu_op_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        alu_op_d = alu_op_q;
        reg_wr   = 1'b0;
        mem_req  = 1'b0;
        mem_wr   = 1'b0;
        pc_en    = 1'b0;
        br_taken = 1'b0;
        done     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            IDLE:   if (bus.start) state_d = FETCH;
            FETCH: begin
                ir_d    = bus.instruction;
                state_d = DECODE;
            end
            // AluOp is registered here so it is stable through EXEC and held afterwards
            DECODE: begin
                alu_op_d = dec.alu_op;
                state_d  = EXEC;
            end
            EXEC: begin
                if (dec.is_halt) begin
                    state_d = HALT;
                end else if (dec.is_branch) begin
                    pc_en    = 1'b1;
                    br_taken = bus.jump;
                    state_d  = FETCH;
                end else if (dec.is_mem) begin
                    state_d = MEM;
                end else if (dec.wr_en) begin
                    state_d = WB;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d   = TRAP;
                    illegal_d = 1'b1;
`else
                    pc_en   = 1'b1;
                    state_d = FETCH;
`endif
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_wr  = dec.is_store;
                if (bus.mem_ack) begin
                    if (dec.is_store) begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_wr  = 1'b1;
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                done = 1'b1;
                if (bus.start) state_d = FETCH;
            end
            TRAP:    done = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign bus.alu_op       = alu_op_q;
    assign bus.rd_addr_a    = rs_of(ir_q);
    assign bus.rd_addr_b    = rt_of(ir_q);
    assign bus.reg_wr_en    = reg_wr;
    assign bus.mem_req      = mem_req;
    assign bus.mem_wr_en    = mem_wr;
    assign bus.pc_en        = pc_en;
    assign bus.branch_taken = br_taken;
    assign bus.done         = done;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_op   = illegal_q;
`else
    assign bus.illegal_op   = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench: per-instruction cycle templates build an expected-output queue checked every cycle.
module tb_ctrl_fsm;
    import ctrl_fsm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_fsm_if bus();

    ctrl_fsm dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       start, jump, ack;
        logic [8:0] instr;
        logic [3:0] alu;
        logic [2:0] ra, rb;
        logic       regwr, memreq, memwr, pcen, br, done, ill;
    } cyc_t;

    cyc_t       q[$];
    logic [3:0] alu_tab [16];
    logic [3:0] m_alu;
    logic [8:0] m_ir;
    logic       m_ill;

    int n_chk = 0, n_pass = 0, cyc_idx = 0;
    int run_idx, n_pc, n_wr, n_mreq, n_mwr, n_done, idx_pc, idx_wr, idx_add, first_done;
    logic br_at_pc, last_ill;
    logic [2:0] last_ra, last_rb;

    logic [16:0] dut_vec;
    assign dut_vec = {bus.alu_op, bus.rd_addr_a, bus.rd_addr_b, bus.reg_wr_en, bus.mem_req,
                      bus.mem_wr_en, bus.pc_en, bus.branch_taken, bus.done, bus.illegal_op};

    function automatic logic [16:0] pack(input cyc_t c);
        return {c.alu, c.ra, c.rb, c.regwr, c.memreq, c.memwr, c.pcen, c.br, c.done, c.ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Defaults for a cycle: don't-care inputs randomised, outputs quiet, held values from the model
    function automatic cyc_t base();
        cyc_t c;
        c.start = 1'($urandom); c.jump = 1'($urandom); c.ack = 1'($urandom);
        c.instr = 9'($urandom);
        c.alu = m_alu; c.ra = m_ir[4:2]; c.rb = {1'b0, m_ir[1:0]};
        c.regwr = 0; c.memreq = 0; c.memwr = 0; c.pcen = 0; c.br = 0; c.done = 0;
        c.ill = m_ill;
        return c;
    endfunction

    task automatic clr_stats();
        run_idx = 0; n_pc = 0; n_wr = 0; n_mreq = 0; n_mwr = 0; n_done = 0;
        idx_pc = -1; idx_wr = -1; idx_add = -1; first_done = -1;
        br_at_pc = 0; last_ill = 0; last_ra = 0; last_rb = 0;
    endtask

    task automatic step(input cyc_t c);
        @(posedge clk); #1;
        bus.start = c.start; bus.instruction = c.instr; bus.jump = c.jump; bus.mem_ack = c.ack;
        @(negedge clk);
        chk($sformatf("cycle%0d_outputs", cyc_idx), 32'(dut_vec), 32'(pack(c)));
        if (bus.mem_req) n_mreq++;
        if (bus.mem_wr_en) n_mwr++;
        if (bus.reg_wr_en) begin n_wr++; idx_wr = run_idx; end
        if (bus.pc_en) begin n_pc++; idx_pc = run_idx; br_at_pc = bus.branch_taken; end
        if (bus.done) begin n_done++; if (first_done < 0) first_done = run_idx; end
        if (bus.alu_op == kADD && idx_add < 0) idx_add = run_idx;
        last_ra = bus.rd_addr_a; last_rb = bus.rd_addr_b; last_ill = bus.illegal_op;
        run_idx++; cyc_idx++;
    endtask

    task automatic run_all();
        while (q.size() > 0) step(q.pop_front());
    endtask

    // Called at a negedge: reset lands mid-cycle and outputs must clear before the next edge
    task automatic do_reset();
        #1 rst = 1'b1;
        bus.start = 0; bus.mem_ack = 0; bus.jump = 0; bus.instruction = '0;
        #1 chk("reset_outputs", 32'(dut_vec), 32'd0);
        @(negedge clk); rst = 1'b0;
        m_alu = 0; m_ir = 0; m_ill = 0;
        q.delete();
    endtask

    task automatic gen_idle(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = base(); c.start = (i == n - 1); q.push_back(c);
        end
    endtask

    // One instruction's full cycle template, starting at its fetch cycle
    task automatic gen_instr(input logic [8:0] ins, input int w, input logic jmp, input int hc,
                             output logic trapped);
        cyc_t c;
        int   op;
        logic st;
        op = int'(ins[8:5]);
        trapped = 0;
        c = base(); c.instr = ins; q.push_back(c);
        m_ir = ins;
        c = base(); q.push_back(c);
        m_alu = alu_tab[op];
        c = base();
        if (op < 8) begin
            q.push_back(c);
            c = base(); c.regwr = 1; c.pcen = 1; q.push_back(c);
        end else if (op == 8 || op == 9) begin
            c.jump = jmp; c.pcen = 1; c.br = jmp; q.push_back(c);
        end else if (op == 10 || op == 11) begin
            st = (op == 11);
            q.push_back(c);
            for (int i = 0; i < w; i++) begin
                c = base(); c.ack = 0; c.memreq = 1; c.memwr = st; q.push_back(c);
            end
            c = base(); c.ack = 1; c.memreq = 1; c.memwr = st; c.pcen = st; q.push_back(c);
            if (!st) begin c = base(); c.regwr = 1; c.pcen = 1; q.push_back(c); end
        end else if (op == 15) begin
            q.push_back(c);
            for (int i = 0; i < hc; i++) begin
                c = base(); c.done = 1; c.start = (i == hc - 1); q.push_back(c);
            end
        end else begin
`ifdef ILLEGAL_TRAP_EN
            q.push_back(c);
            m_ill = 1; trapped = 1;
            for (int i = 0; i < hc; i++) begin c = base(); c.done = 1; q.push_back(c); end
`else
            c.pcen = 1; q.push_back(c);
`endif
        end
    endtask

    initial begin
        logic tr;
        logic [3:0] op;
        alu_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                    4'd9, 4'd10, 4'd11, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0};
        m_alu = 0; m_ir = 0; m_ill = 0;
        bus.start = 0; bus.mem_ack = 0; bus.jump = 0; bus.instruction = '0;
        @(negedge clk);
        do_reset();

        // ADD R2,R1
        clr_stats(); gen_idle(1); gen_instr({4'd0, 3'd2, 2'd1}, 0, 0, 1, tr); run_all();
        chk("add_aluop_cycle", 32'(idx_add), 32'd3);
        chk("add_wr_count", 32'(n_wr), 32'd1);
        chk("add_wr_cycle", 32'(idx_wr), 32'd4);
        chk("add_pc_cycle", 32'(idx_pc), 32'd4);
        chk("add_rd_a", 32'(last_ra), 32'd2);
        chk("add_rd_b", 32'(last_rb), 32'd1);

        // BEQ R1,R0 taken / not taken
        for (int j = 1; j >= 0; j--) begin
            do_reset(); clr_stats(); gen_idle(1);
            gen_instr({4'd8, 3'd1, 2'd0}, 0, 1'(j), 1, tr); run_all();
            chk("beq_pc_cycle", 32'(idx_pc), 32'd3);
            chk("beq_branch_taken", 32'(br_at_pc), 32'(j));
            chk("beq_no_write", 32'(n_wr), 32'd0);
        end

        // LDR with three wait cycles
        do_reset(); clr_stats(); gen_idle(1); gen_instr({4'd10, 3'd3, 2'd2}, 3, 0, 1, tr); run_all();
        chk("ldr_memreq_cycles", 32'(n_mreq), 32'd4);
        chk("ldr_memwr_cycles", 32'(n_mwr), 32'd0);
        chk("ldr_wr_cycle", 32'(idx_wr), 32'd8);
        chk("ldr_pc_cycle", 32'(idx_pc), 32'd8);

        // STR with immediate ack
        do_reset(); clr_stats(); gen_idle(1); gen_instr({4'd11, 3'd4, 2'd3}, 0, 0, 1, tr); run_all();
        chk("str_memreq_cycles", 32'(n_mreq), 32'd1);
        chk("str_memwr_cycles", 32'(n_mwr), 32'd1);
        chk("str_pc_cycle", 32'(idx_pc), 32'd4);
        chk("str_no_write", 32'(n_wr), 32'd0);

        // HALT twice back-to-back, then an ADD
        do_reset(); clr_stats(); gen_idle(1);
        gen_instr({4'd15, 5'd0}, 0, 0, 2, tr);
        gen_instr({4'd15, 5'd0}, 0, 0, 2, tr);
        gen_instr({4'd0, 3'd5, 2'd2}, 0, 0, 1, tr);
        run_all();
        chk("halt_done_first_cycle", 32'(first_done), 32'd4);
        chk("halt_done_cycles", 32'(n_done), 32'd4);
        chk("halt_pc_pulses", 32'(n_pc), 32'd1);

        // Reserved opcode
        do_reset(); clr_stats(); gen_idle(1); gen_instr({4'd12, 5'd9}, 0, 0, 3, tr); run_all();
`ifdef ILLEGAL_TRAP_EN
        chk("rsv_illegal_sticky", 32'(last_ill), 32'd1);
        chk("rsv_done_cycles", 32'(n_done), 32'd3);
        chk("rsv_no_pc", 32'(n_pc), 32'd0);
`else
        chk("rsv_nop_pc_cycle", 32'(idx_pc), 32'd3);
        chk("rsv_no_write", 32'(n_wr), 32'd0);
        chk("rsv_illegal_low", 32'(last_ill), 32'd0);
`endif

        // Reset while MemReq is asserted
        do_reset(); clr_stats(); gen_idle(1); gen_instr({4'd10, 3'd1, 2'd1}, 5, 0, 1, tr);
        for (int i = 0; i < 5; i++) step(q.pop_front());
        chk("memreq_before_reset", 32'(bus.mem_req), 32'd1);
        do_reset();

        // Random programs
        for (int s = 0; s < 10; s++) begin
            do_reset();
            gen_idle($urandom_range(1, 3));
            for (int k = 0; k < 25; k++) begin
                op = 4'($urandom_range(0, 15));
                gen_instr({op, 5'($urandom)}, $urandom_range(0, 4), 1'($urandom),
                          $urandom_range(1, 3), tr);
                if (tr) break;
            end
            run_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
